// File: rtl/gcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// gcd_seq_pkg
// Shared definitions for the GCD job sequencer:
//   - seq_state_t : FSM state encoding (S_IDLE, S_START, S_WAIT, S_ACK)
//   - DEF_WIDTH   : default operand/result width (matches the ee354_GCD core)
//   - DEF_DEPTH   : default operand queue depth
//   - sat_inc16   : saturating 16-bit increment, used by the optional cycle
//                   counter (GCD_SEQ_CYCLES_EN builds)
// -----------------------------------------------------------------------------
package gcd_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } seq_state_t;

  // Holds at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gcd_seq_fifo.sv
// -----------------------------------------------------------------------------
// gcd_seq_fifo
// DEPTH-entry FIFO holding operand pairs (A, B) for the GCD job sequencer.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
// There is no full bypass: a push into a full FIFO is dropped, as is a pop
// from an empty one.
//
// Ports:
//   clk           : clock
//   rst_n         : synchronous active-low reset (empties the FIFO)
//   push          : write push_a/push_b this cycle (ignored when full)
//   push_a/push_b : operand pair to store
//   pop           : advance the read pointer this cycle (ignored when empty)
//   head_a/head_b : oldest stored pair (valid when !empty)
//   full / empty  : occupancy flags
//   count         : number of stored entries, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module gcd_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_a,
  input  logic [WIDTH-1:0]         push_b,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_a,
  output logic [WIDTH-1:0]         head_b,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head_a  = mem_a[rd_ptr];
  assign head_b  = mem_b[rd_ptr];

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_a[wr_ptr] <= push_a;
      mem_b[wr_ptr] <= push_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// -----------------------------------------------------------------------------
// gcd_job_sequencer
// Feeds operand pairs from a small queue into the single-job ee354_GCD core,
// drives its Start/Ack handshake and presents each result (with the operands
// that produced it) on a valid/ack result port.
//
// Handshakes:
//   Input  : a pair is taken on a clock edge where SCEN & In_Valid & In_Ready.
//            In_Ready depends only on queue occupancy, never on In_Valid.
//   Result : Res_Valid/Res_GCD/Res_A/Res_B hold until an edge with
//            SCEN & Res_Ack; a new capture on that same edge replaces the data
//            and keeps Res_Valid high. Res_Ack while Res_Valid=0 is ignored.
//
// Ports:
//   Clk, Reset (sync, active low), SCEN (global clock enable, shared with core)
//   In_Valid, In_Ready, In_A, In_B         : operand input port
//   Ain, Bin, Start, Ack, q_Done, AB_GCD   : core interface
//   Res_Valid, Res_Ack, Res_GCD, Res_A, Res_B : result port
//   Busy      : FSM not idle, or queue non-empty
//   Jobs_Done : completed-job counter (wraps 255 -> 0)
//   Res_Cycles: S_START+S_WAIT cycles of the last job (GCD_SEQ_CYCLES_EN only)
//   Dbg_State : current FSM state
//
// Build option: define GCD_SEQ_CYCLES_EN to add the per-job cycle counter and
// the Res_Cycles port.
// -----------------------------------------------------------------------------
module gcd_job_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SCEN,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  output logic [WIDTH-1:0] Ain,
  output logic [WIDTH-1:0] Bin,
  output logic             Start,
  output logic             Ack,
  input  logic             q_Done,
  input  logic [WIDTH-1:0] AB_GCD,
  output logic             Res_Valid,
  input  logic             Res_Ack,
  output logic [WIDTH-1:0] Res_GCD,
  output logic [WIDTH-1:0] Res_A,
  output logic [WIDTH-1:0] Res_B,
  output logic             Busy,
  output logic [7:0]       Jobs_Done,
`ifdef GCD_SEQ_CYCLES_EN
  output logic [15:0]      Res_Cycles,
`endif
  output seq_state_t       Dbg_State
);

  seq_state_t               state;
  logic [WIDTH-1:0]         head_a;
  logic [WIDTH-1:0]         head_b;
  logic                     q_full;
  logic                     q_empty;
  logic [$clog2(DEPTH):0]   q_count;
  logic                     do_push;
  logic                     do_pop;
  logic                     capture;

  assign In_Ready  = ~q_full;
  assign do_push   = SCEN & In_Valid & ~q_full;
  assign do_pop    = SCEN & (state == S_IDLE) & ~q_empty;
  // Capture only when the result slot is free or being emptied this edge;
  // otherwise the core simply stays in its Done state.
  assign capture   = SCEN & (state == S_WAIT) & q_Done & (~Res_Valid | Res_Ack);
  assign Busy      = (state != S_IDLE) | (q_count != '0);
  assign Dbg_State = state;

  gcd_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk    (Clk),
    .rst_n  (Reset),
    .push   (do_push),
    .push_a (In_A),
    .push_b (In_B),
    .pop    (do_pop),
    .head_a (head_a),
    .head_b (head_b),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

  // FSM with registered Moore outputs Start/Ack, operand registers,
  // result register and job counter. Nothing moves while SCEN=0.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      Start     <= 1'b0;
      Ack       <= 1'b0;
      Ain       <= '0;
      Bin       <= '0;
      Res_Valid <= 1'b0;
      Res_GCD   <= '0;
      Res_A     <= '0;
      Res_B     <= '0;
      Jobs_Done <= 8'd0;
    end else if (SCEN) begin
      if (capture) begin
        Res_Valid <= 1'b1;
        Res_GCD   <= AB_GCD;
        Res_A     <= Ain;
        Res_B     <= Bin;
        Jobs_Done <= Jobs_Done + 8'd1;
      end else if (Res_Ack) begin
        Res_Valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!q_empty) begin
            // Ain/Bin stay put from here until the job leaves S_ACK.
            Ain   <= head_a;
            Bin   <= head_b;
            Start <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          Start <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            Ack   <= 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          Ack   <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Start <= 1'b0;
          Ack   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GCD_SEQ_CYCLES_EN
  logic [15:0] cyc_cnt;

  // Cleared on entry to S_START, counts every enabled S_START/S_WAIT cycle.
  // The value copied out includes the capture cycle itself.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cyc_cnt    <= 16'd0;
      Res_Cycles <= 16'd0;
    end else if (SCEN) begin
      if (do_pop) begin
        cyc_cnt <= 16'd0;
      end else if (state == S_START || state == S_WAIT) begin
        cyc_cnt <= sat_inc16(cyc_cnt);
      end
      if (capture) begin
        Res_Cycles <= sat_inc16(cyc_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gcd_job_sequencer
// Self-checking bench for gcd_job_sequencer. A behavioural stand-in for the
// ee354_GCD core raises q_Done in the 4th cycle after it sees Start and holds
// it until Ack. Every accepted operand pair is queued with its expected GCD;
// a compare process checks each result as it is handed over on the result
// port, together with Start/Ack pulse shape. Directed tests add hand-computed
// literal checks.
// -----------------------------------------------------------------------------
module tb_gcd_job_sequencer;
  import gcd_seq_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         Clk = 1'b0;
  logic         Reset;
  logic         SCEN;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] In_A, In_B;
  logic [W-1:0] Ain, Bin;
  logic         Start, Ack;
  logic         q_Done;
  logic [W-1:0] AB_GCD;
  logic         Res_Valid, Res_Ack;
  logic [W-1:0] Res_GCD, Res_A, Res_B;
  logic         Busy;
  logic [7:0]   Jobs_Done;
  seq_state_t   Dbg_State;
`ifdef GCD_SEQ_CYCLES_EN
  logic [15:0]  Res_Cycles;
`endif

  always #5 Clk = ~Clk;

  gcd_job_sequencer #(.DEPTH(4), .WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .SCEN      (SCEN),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_A      (In_A),
    .In_B      (In_B),
    .Ain       (Ain),
    .Bin       (Bin),
    .Start     (Start),
    .Ack       (Ack),
    .q_Done    (q_Done),
    .AB_GCD    (AB_GCD),
    .Res_Valid (Res_Valid),
    .Res_Ack   (Res_Ack),
    .Res_GCD   (Res_GCD),
    .Res_A     (Res_A),
    .Res_B     (Res_B),
    .Busy      (Busy),
    .Jobs_Done (Jobs_Done),
`ifdef GCD_SEQ_CYCLES_EN
    .Res_Cycles(Res_Cycles),
`endif
    .Dbg_State (Dbg_State)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endfunction

  function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x[7:0];
  endfunction

  // ---------------- core stand-in ----------------
  localparam int DONE_LAT = 4;
  logic core_busy;
  int   core_wcnt;

  always @(posedge Clk) begin
    if (!Reset) begin
      core_busy <= 1'b0;
      core_wcnt <= 0;
      q_Done    <= 1'b0;
      AB_GCD    <= '0;
    end else if (SCEN) begin
      if (!core_busy) begin
        if (Start) begin
          core_busy <= 1'b1;
          core_wcnt <= 1;
          q_Done    <= (DONE_LAT == 1);
          AB_GCD    <= gcd_f(Ain, Bin);
        end
      end else if (q_Done) begin
        if (Ack) begin
          q_Done    <= 1'b0;
          core_busy <= 1'b0;
        end
      end else begin
        core_wcnt <= core_wcnt + 1;
        q_Done    <= (core_wcnt + 1 == DONE_LAT);
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [23:0] exp_q[$];   // {gcd, a, b} in acceptance order
  int   consumed    = 0;
  int   start_rises = 0;
  int   ack_rises   = 0;
  logic prev_start  = 1'b0;
  logic prev_ack    = 1'b0;

  always @(negedge Clk) begin
    logic [23:0] e;
    if (Reset && SCEN) begin
      if (Start) chk("start_single_cycle", {63'd0, prev_start}, 64'd0);
      if (Ack)   chk("ack_single_cycle", {63'd0, prev_ack}, 64'd0);
      if (Start && Ack) chk("start_ack_exclusive", 64'd1, 64'd0);
      if (Start && !prev_start) start_rises++;
      if (Ack && !prev_ack) ack_rises++;
      prev_start = Start;
      prev_ack   = Ack;
      if (Res_Valid && Res_Ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          consumed++;
          chk("res_gcd", {56'd0, Res_GCD}, {56'd0, e[23:16]});
          chk("res_a", {56'd0, Res_A}, {56'd0, e[15:8]});
          chk("res_b", {56'd0, Res_B}, {56'd0, e[7:0]});
          chk("jobs_done_at_handover", {56'd0, Jobs_Done}, {56'd0, consumed[7:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    In_Valid = 1'b0;
    exp_q.delete();
    consumed    = 0;
    start_rises = 0;
    ack_rises   = 0;
    prev_start  = 1'b0;
    prev_ack    = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  // Offers a pair from posedge+1 until taken; returns the cycles it waited.
  task automatic push(input logic [7:0] a, input logic [7:0] b, output int waited);
    bit done;
    waited = 0;
    done   = 1'b0;
    In_A = a; In_B = b; In_Valid = 1'b1;
    while (!done) begin
      @(negedge Clk);
      if (In_Ready && SCEN) begin
        @(posedge Clk);
        exp_q.push_back({gcd_f(a, b), a, b});
        #1;
        done = 1'b1;
      end else if (waited == 200) begin
        chk("push_timeout", 64'd0, 64'd1);
        step();
        done = 1'b1;
      end else begin
        step();
        waited++;
      end
    end
    In_Valid = 1'b0;
  endtask

  // Steps until Busy is low (checked at negedge); ends at posedge+1.
  task automatic wait_not_busy(input int budget);
    int n;
    n = 0;
    @(negedge Clk);
    while (Busy && n < budget) begin
      step();
      n++;
      @(negedge Clk);
    end
    if (Busy) chk("busy_timeout", 64'd1, 64'd0);
    step();
  endtask

  // Counts edges until Res_Valid is seen high; ends at negedge.
  task automatic wait_res_valid(input int budget, output int n);
    n = 0;
    @(negedge Clk);
    while (!Res_Valid && n < budget) begin
      step();
      n++;
      @(negedge Clk);
    end
    if (!Res_Valid) chk("res_valid_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- test sequence ----------------
  int          w;
  int          base_lat;
  int          frz_lat;
  logic [63:0] snap;

  initial begin
    Reset = 1'b0; SCEN = 1'b1; In_Valid = 1'b0; In_A = '0; In_B = '0; Res_Ack = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;

    // Reset state
    @(negedge Clk);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_in_ready", {63'd0, In_Ready}, 64'd1);
    chk("rst_res_valid", {63'd0, Res_Valid}, 64'd0);
    chk("rst_jobs_done", {56'd0, Jobs_Done}, 64'd0);
    chk("rst_start_ack", {62'd0, Start, Ack}, 64'd0);
    chk("rst_operands", {48'd0, Ain, Bin}, 64'd0);
    chk("rst_result", {40'd0, Res_GCD, Res_A, Res_B}, 64'd0);
    step();

    // Single job, result left unacknowledged
    do_reset();
    Res_Ack = 1'b0;
    push(8'd36, 8'd24, w);
    @(negedge Clk);
    chk("single_start_not_yet", {63'd0, Start}, 64'd0);
    step();
    @(negedge Clk);
    chk("single_start_high", {63'd0, Start}, 64'd1);
    chk("single_ain_bin", {48'd0, Ain, Bin}, {48'd0, 8'd36, 8'd24});
    step();
    wait_not_busy(50);
    @(negedge Clk);
    chk("single_res_valid", {63'd0, Res_Valid}, 64'd1);
    chk("single_res_gcd", {56'd0, Res_GCD}, 64'd12);
    chk("single_res_a", {56'd0, Res_A}, 64'd36);
    chk("single_res_b", {56'd0, Res_B}, 64'd24);
    chk("single_jobs_done", {56'd0, Jobs_Done}, 64'd1);
    chk("single_start_pulses", start_rises, 64'd1);
    chk("single_ack_pulses", ack_rises, 64'd1);
`ifdef GCD_SEQ_CYCLES_EN
    chk("single_res_cycles", {48'd0, Res_Cycles}, 64'd5);
`endif
    step();

    // Queue fill with Res_Ack tied high
    do_reset();
    Res_Ack = 1'b1;
    push(8'd36, 8'd24, w);
    push(8'd5, 8'd15, w);
    push(8'd7, 8'd7, w);
    push(8'd13, 8'd8, w);
    push(8'd9, 8'd6, w);
    @(negedge Clk);
    chk("fill_in_ready_full", {63'd0, In_Ready}, 64'd0);
    step();
    push(8'd20, 8'd8, w);
    chk("fill_offer_waited", {63'd0, (w > 0)}, 64'd1);
    wait_not_busy(200);
    step();
    @(negedge Clk);
    chk("fill_jobs_done", {56'd0, Jobs_Done}, 64'd6);
    chk("fill_results_handed_over", consumed, 64'd6);
    chk("fill_exp_q_empty", exp_q.size(), 64'd0);
    step();

    // Result back-pressure across two jobs
    do_reset();
    Res_Ack = 1'b0;
    push(8'd36, 8'd24, w);
    push(8'd5, 8'd15, w);
    w = 0;
    @(negedge Clk);
    while (!(q_Done && Res_Valid && !Ack) && w < 100) begin
      step(); w++; @(negedge Clk);
    end
    chk("bp_second_done_seen", {63'd0, (q_Done && Res_Valid && !Ack)}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge Clk);
      chk("bp_stall_ack_low", {63'd0, Ack}, 64'd0);
      chk("bp_stall_first_result", {56'd0, Res_GCD}, 64'd12);
    end
    step();
    Res_Ack = 1'b1;
    step();
    @(negedge Clk);
    chk("bp_valid_stays", {63'd0, Res_Valid}, 64'd1);
    chk("bp_second_result", {40'd0, Res_GCD, Res_A, Res_B}, {40'd0, 8'd5, 8'd5, 8'd15});
    chk("bp_ack_now", {63'd0, Ack}, 64'd1);
    chk("bp_jobs_done", {56'd0, Jobs_Done}, 64'd2);
    step();
    wait_not_busy(50);
    chk("bp_all_handed_over", consumed, 64'd2);

    // SCEN freeze: baseline latency, then the same job frozen for 10 cycles
    do_reset();
    Res_Ack = 1'b1;
    push(8'd36, 8'd24, w);
    wait_res_valid(100, base_lat);
    chk("lat_base", base_lat, 64'd6);
    step();
    wait_not_busy(50);

    push(8'd36, 8'd24, w);
    step();
    step();
    snap = {9'd0, Start, Ack, Ain, Bin, Res_Valid, Res_GCD, Res_A, Res_B,
            Busy, In_Ready, Jobs_Done, Dbg_State};
    SCEN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge Clk);
      chk("freeze_outputs_held",
          {9'd0, Start, Ack, Ain, Bin, Res_Valid, Res_GCD, Res_A, Res_B,
           Busy, In_Ready, Jobs_Done, Dbg_State}, snap);
    end
    step();
    SCEN = 1'b1;
    wait_res_valid(100, frz_lat);
    chk("lat_frozen_delta", frz_lat + 12, base_lat + 10);
    chk("lat_frozen_total", frz_lat + 12, 64'd16);
    step();
    wait_not_busy(50);
    chk("freeze_results_handed_over", consumed, 64'd2);

    // Reset mid-job with two jobs queued
    do_reset();
    Res_Ack = 1'b0;
    push(8'd36, 8'd24, w);
    push(8'd5, 8'd15, w);
    push(8'd7, 8'd7, w);
    do_reset();
    @(negedge Clk);
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_in_ready", {63'd0, In_Ready}, 64'd1);
    chk("midrst_res_valid", {63'd0, Res_Valid}, 64'd0);
    chk("midrst_jobs_done", {56'd0, Jobs_Done}, 64'd0);
    chk("midrst_start_ack", {62'd0, Start, Ack}, 64'd0);
    repeat (5) step();
    @(negedge Clk);
    chk("midrst_stays_idle", {62'd0, Busy, Start}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
